// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, FSM states, EXEC control bundle.
// Pure declarations; no logic, no latency.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_MUL = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic addsub;
        logic xor_ctrl;
        logic mul_out_ctrl;
    } alu_ctl_t;

    function automatic alu_ctl_t exec_ctl(input opcode_e op);
        alu_ctl_t c;
        c = '0;
        case (op)
            OP_SUB:  c.addsub       = 1'b1;
            OP_XOR:  c.xor_ctrl     = 1'b1;
            OP_MUL:  c.mul_out_ctrl = 1'b1;
            default: c              = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_iter_counter.sv
// 4-bit loadable down-counter with zero flag; load wins over decrement, 1-cycle update.
// Decrement saturates at zero so a finished count never wraps back to 15.
module iter_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Drives an external ALU through iter+1 LOAD/EXEC pairs, then captures its result in DONE.
// Start-to-done latency 2*(iter+1)+1 cycles; start is ignored while busy (no queuing).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [3:0]       iter,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_out,
    input  logic [WIDTH-1:0] mul_acc_out,
    output logic [WIDTH-1:0] a_bus,
    output logic [WIDTH-1:0] b_bus,
    output logic             a_enable,
    output logic             acc_enable,
    output logic             addsub,
    output logic             xor_ctrl,
    output logic             mul_out_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi
);

    state_e           r_state;
    opcode_e          r_opcode;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_a_enable;
    logic             r_a_from_acc;
    logic             r_acc_enable;
    alu_ctl_t         r_ctl;
    logic             r_busy;
    logic             r_done;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    assign w_cnt_load = (r_state == ST_IDLE) && start;
    assign w_cnt_dec  = (r_state == ST_EXEC) && !w_cnt_zero;

    iter_counter u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_val  (iter),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_opcode     <= OP_ADD;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_result_hi  <= '0;
            r_a_enable   <= 1'b0;
            r_a_from_acc <= 1'b0;
            r_acc_enable <= 1'b0;
            r_ctl        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_a_enable   <= 1'b0;
            r_acc_enable <= 1'b0;
            r_ctl        <= '0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opcode     <= opcode_e'(opcode);
                        r_op_a       <= op_a;
                        r_op_b       <= op_b;
                        r_a_enable   <= 1'b1;
                        r_a_from_acc <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_acc_enable <= 1'b1;
                    r_ctl        <= exec_ctl(r_opcode);
                    r_state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_cnt_zero) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // later iterations feed the accumulator back as the A operand
                        r_a_enable   <= 1'b1;
                        r_a_from_acc <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_result     <= acc_out;
                    r_result_hi  <= mul_acc_out;
                    r_a_from_acc <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a_bus        = r_a_enable ? (r_a_from_acc ? acc_out : r_op_a) : '0;
    assign b_bus        = r_acc_enable ? r_op_b : '0;
    assign a_enable     = r_a_enable;
    assign acc_enable   = r_acc_enable;
    assign addsub       = r_ctl.addsub;
    assign xor_ctrl     = r_ctl.xor_ctrl;
    assign mul_out_ctrl = r_ctl.mul_out_ctrl;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_hi    = r_result_hi;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU attached; directed vector table plus
// hand-written sequences for start-while-busy and mid-operation reset.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  opcode;
    logic [3:0]  iter;
    logic [15:0] op_a, op_b;
    logic [15:0] acc_out, mul_acc_out;
    logic [15:0] a_bus, b_bus;
    logic        a_enable, acc_enable, addsub, xor_ctrl, mul_out_ctrl;
    logic        busy, done;
    logic [15:0] result, result_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .iter         (iter),
        .op_a         (op_a),
        .op_b         (op_b),
        .acc_out      (acc_out),
        .mul_acc_out  (mul_acc_out),
        .a_bus        (a_bus),
        .b_bus        (b_bus),
        .a_enable     (a_enable),
        .acc_enable   (acc_enable),
        .addsub       (addsub),
        .xor_ctrl     (xor_ctrl),
        .mul_out_ctrl (mul_out_ctrl),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_hi    (result_hi)
    );

    // Behavioural ALU: A register, accumulator and multiplier high half.
    logic [15:0] m_a, m_acc, m_hi;
    logic [31:0] m_prod;
    assign m_prod      = {16'h0, m_a} * {16'h0, b_bus};
    assign acc_out     = m_acc;
    assign mul_acc_out = m_hi;

    always @(posedge clk) begin
        if (rst) begin
            m_a   <= 16'h0;
            m_acc <= 16'h0;
            m_hi  <= 16'h0;
        end else begin
            if (a_enable) m_a <= a_bus;
            if (acc_enable) begin
                if (mul_out_ctrl) begin
                    m_acc <= m_prod[15:0];
                    m_hi  <= m_prod[31:16];
                end else begin
                    m_hi <= 16'h0;
                    if (xor_ctrl)    m_acc <= m_a ^ b_bus;
                    else if (addsub) m_acc <= m_a - b_bus;
                    else             m_acc <= m_a + b_bus;
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  opc;
        logic [3:0]  it;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_ctl(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b000;
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [79:0] all_outs();
        return {9'b0, a_bus, b_bus, a_enable, acc_enable, addsub, xor_ctrl, mul_out_ctrl,
                busy, done, result, result_hi};
    endfunction

    // Called right after a negedge; start is raised in the current cycle (cycle 0).
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          execs;
        bit          ctl_ok;
        bit          first_load;
        logic [15:0] exp_a;
        lat = -1; execs = 0; ctl_ok = 1'b1; first_load = 1'b1;
        opcode = v.opc; iter = v.it; op_a = v.a; op_b = v.b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opcode = ~v.opc; iter = ~v.it; op_a = 16'h5A5A; op_b = 16'hC3C3;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (a_enable) begin
                exp_a = first_load ? v.a : acc_out;
                if (a_bus !== exp_a) ctl_ok = 1'b0;
                first_load = 1'b0;
            end else if (a_bus !== 16'h0) ctl_ok = 1'b0;
            if (acc_enable) begin
                execs++;
                if (b_bus !== v.b) ctl_ok = 1'b0;
                if ({addsub, xor_ctrl, mul_out_ctrl} !== exp_ctl(v.opc)) ctl_ok = 1'b0;
            end else if (b_bus !== 16'h0 || addsub || xor_ctrl || mul_out_ctrl) ctl_ok = 1'b0;
            if (a_enable && acc_enable) ctl_ok = 1'b0;
            if (busy !== 1'b1) ctl_ok = 1'b0;
            if (done === 1'b1) lat = c;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d exec_count", idx), execs, int'(v.it) + 1);
        chk($sformatf("v%0d controls", idx), ctl_ok, 1'b1);
        @(negedge clk);
        chk($sformatf("v%0d busy_done_after", idx), {busy, done}, 2'b00);
        chk($sformatf("v%0d result", idx), {result_hi, result}, {v.hi, v.res});
    endtask

    initial begin
        int dones;
        int done_cyc;

        vecs[0] = '{2'b00, 4'd0,  16'h0005, 16'h0003, 16'h0008, 16'h0000, 3};
        vecs[1] = '{2'b01, 4'd0,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 3};
        vecs[2] = '{2'b00, 4'd3,  16'h0001, 16'h0002, 16'h0009, 16'h0000, 9};
        vecs[3] = '{2'b10, 4'd1,  16'hAAAA, 16'hFFFF, 16'hAAAA, 16'h0000, 5};
        vecs[4] = '{2'b11, 4'd0,  16'h0003, 16'h0004, 16'h000C, 16'h0000, 3};
        vecs[5] = '{2'b00, 4'd15, 16'h0001, 16'h0001, 16'h0011, 16'h0000, 33};
        vecs[6] = '{2'b00, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3};
        vecs[7] = '{2'b11, 4'd0,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 3};
        vecs[8] = '{2'b11, 4'd1,  16'h0003, 16'h0004, 16'h0030, 16'h0000, 5};
        vecs[9] = '{2'b01, 4'd2,  16'h000A, 16'h0003, 16'h0001, 16'h0000, 7};

        // Reset with start held high: start must be dropped, everything zero.
        rst = 1'b1; start = 1'b1; opcode = 2'b00; iter = 4'd0; op_a = 16'h1111; op_b = 16'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", all_outs(), 80'h0);

        // First cycle with rst low accepts start.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Start pulses at cycles 2 and 4 during an iter=3 operation are ignored.
        opcode = 2'b00; iter = 4'd3; op_a = 16'h0001; op_b = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0; done_cyc = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                done_cyc = c;
            end
            start = (c == 2 || c == 4);
            opcode = 2'b11; iter = 4'd1;
        end
        start = 1'b0;
        chk("busy_start_done_count", dones, 1);
        chk("busy_start_done_cycle", done_cyc, 9);
        chk("busy_start_result", result, 16'h0009);
        chk("busy_start_idle", busy, 1'b0);

        // Reset asserted in cycle 4 of an operation; fresh start in cycle 5.
        opcode = 2'b00; iter = 4'd3; op_a = 16'h0001; op_b = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midop_reset_outputs", all_outs(), 80'h0);
        run_vec(vecs[0], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of operand, bus and result ports.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 opcode  in  2  00 ADD, 01 SUB, 10 XOR, 11 MUL.
REQ-006 iter  in  4  repeat count; operation executes iter+1 times (1..16).
REQ-007 op_a  in  WIDTH  first A operand.
REQ-008 op_b  in  WIDTH  B operand, constant for all iterations.
REQ-009 acc_out  in  WIDTH  ALU accumulator value (feedback).
REQ-010 mul_acc_out  in  WIDTH  ALU multiplier-accumulator value (feedback).
REQ-011 a_bus  out  WIDTH  ALU A input.
REQ-012 b_bus  out  WIDTH  ALU B input.
REQ-013 a_enable, acc_enable, addsub, xor_ctrl, mul_out_ctrl  out  1 each  ALU control strobes.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 result, result_hi  out  WIDTH each  captured acc_out and mul_acc_out, held until the next done.

Function
REQ-017 States SHALL be IDLE, LOAD, EXEC, DONE; all transitions occur on rising clk.
REQ-018 IDLE: start=1 SHALL latch opcode, iter, op_b and op_a, load remaining-count = iter, and go to LOAD; start=0 stays IDLE.
REQ-019 LOAD: a_enable=1; a_bus SHALL equal latched op_a on the first iteration and acc_out on later iterations; next state EXEC.
REQ-020 EXEC: b_bus = latched op_b, acc_enable=1, control per REQ-021; next state LOAD with remaining-1 if remaining≠0, else DONE.
REQ-021 EXEC controls: ADD addsub=0 xor_ctrl=0 mul_out_ctrl=0; SUB addsub=1 xor_ctrl=0 mul_out_ctrl=0; XOR addsub=0 xor_ctrl=1 mul_out_ctrl=0; MUL addsub=0 xor_ctrl=0 mul_out_ctrl=1.
REQ-022 Outside EXEC, addsub, xor_ctrl, mul_out_ctrl and acc_enable SHALL be 0; outside LOAD, a_enable SHALL be 0.
REQ-023 DONE: result <= acc_out, result_hi <= mul_acc_out, done=1 for exactly this cycle, next state IDLE.
REQ-024 Latency: start accepted in cycle 0 -> done asserted in cycle 2*(iter+1)+1.
REQ-025 busy SHALL be 1 in LOAD, EXEC, DONE and 0 in IDLE.
REQ-026 start while busy SHALL be ignored; no queuing.
REQ-027 Changes to opcode, iter, op_a, op_b after acceptance SHALL NOT affect the operation in progress.
REQ-028 Arithmetic wraps modulo 2^WIDTH (performed by ALU); sequencer adds no carry/overflow logic.
REQ-029 iter=15 SHALL yield exactly 16 EXEC cycles; counter SHALL NOT wrap to restart.
REQ-030 a_bus and b_bus SHALL be 0 when not driven per REQ-019/020.

Reset
REQ-031 rst=1 SHALL force IDLE and zero all outputs, latched operands and counter on the next edge, including mid-operation.
REQ-032 start asserted in the same cycle as rst SHALL be dropped.
REQ-033 First start is accepted in the first cycle with rst=0.

Structure
REQ-034 Opcode encodings, state encoding and WIDTH default SHALL live in shared package alu_pkg.
REQ-035 A single sub-module, iter_counter (4-bit loadable down-counter with zero flag), is permitted; remaining logic is one FSM with registered outputs.

Verification
REQ-036 ADD op_a=5 op_b=3 iter=0, ALU attached -> done at cycle 3, result=0x0008, busy low next cycle.
REQ-037 SUB op_a=3 op_b=5 iter=0 -> result=0xFFFE; addsub=1 only during EXEC cycle 2.
REQ-038 ADD op_a=1 op_b=2 iter=3 -> four EXEC cycles, a_bus=acc_out from second LOAD, result=0x0009, done at cycle 9.
REQ-039 XOR op_a=0xAAAA op_b=0xFFFF iter=1 -> result=0xAAAA; MUL 3x4 iter=0 -> {result_hi,result} low 32 bits = 12.
REQ-040 start pulsed at cycles 2 and 4 during an iter=3 op -> ignored, exactly one done; rst at cycle 4 -> all outputs 0 at cycle 5, no done, fresh start at cycle 5 completes normally.
